// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes and entry FSM state type for keypad_operand_entry
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_PLUS      = 4'd10;
  localparam logic [3:0] KEY_EQ        = 4'd11;
  localparam logic [3:0] KEY_CLR       = 4'd12;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, SEND} entry_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - turns scanner key_flag/key_code hits into one strobe per press
module key_debounce #(
  parameter int PRESS_HITS     = 3,
  parameter int RELEASE_CYCLES = 8192
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       key_flag,
  input  logic [4:0] key_code,
  output logic       key_strobe,
  output logic [3:0] key_last
);

  localparam int HW = $clog2(PRESS_HITS + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  logic          flag_q, flag_d;
  logic          locked_q, locked_d;
  logic [4:0]    cand_q, cand_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [RW-1:0] rel_cnt_q, rel_cnt_d;
  logic          strobe_q, strobe_d;
  logic [3:0]    last_q, last_d;

  always_comb begin
    flag_d    = key_flag;
    rel_cnt_d = rel_cnt_q;
    locked_d  = locked_q;
    cand_d    = cand_q;
    hit_cnt_d = hit_cnt_q;
    strobe_d  = 1'b0;
    last_d    = last_q;

    if (key_flag) begin
      rel_cnt_d = '0;
    end else if (rel_cnt_q != RW'(RELEASE_CYCLES)) begin
      rel_cnt_d = rel_cnt_q + RW'(1);
    end

    // Release can never coincide with a hit: any key_flag cycle zeroes rel_cnt_d.
    if (rel_cnt_d == RW'(RELEASE_CYCLES)) begin
      locked_d  = 1'b0;
      cand_d    = '0;
      hit_cnt_d = '0;
    end

    if (key_flag && !flag_q && !locked_q) begin
      if (key_code == cand_q) begin
        hit_cnt_d = hit_cnt_q + HW'(1);
      end else begin
        cand_d    = key_code;
        hit_cnt_d = HW'(1);
      end
      if (hit_cnt_d == HW'(PRESS_HITS)) begin
        strobe_d = 1'b1;
        last_d   = cand_d[3:0];
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      flag_q    <= 1'b0;
      locked_q  <= 1'b0;
      cand_q    <= '0;
      hit_cnt_q <= '0;
      rel_cnt_q <= '0;
      strobe_q  <= 1'b0;
      last_q    <= '0;
    end else begin
      flag_q    <= flag_d;
      locked_q  <= locked_d;
      cand_q    <= cand_d;
      hit_cnt_q <= hit_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      strobe_q  <= strobe_d;
      last_q    <= last_d;
    end
  end

  assign key_strobe = strobe_q;
  assign key_last   = last_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// rtl/keypad_operand_entry.sv - assembles decimal operands A/B from key presses for the adder
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESS_HITS     = 3,
  parameter int RELEASE_CYCLES = 8192
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             key_flag,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] entry_value,
  output logic             entry_sel,
  output logic             key_strobe,
  output logic [3:0]       key_last,
  output logic             ovf_err
);

  entry_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] cur;
  logic [WIDTH+3:0] cur_w, next_val;
  logic             overflow;

  key_debounce #(
    .PRESS_HITS     (PRESS_HITS),
    .RELEASE_CYCLES (RELEASE_CYCLES)
  ) u_debounce (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .key_flag   (key_flag),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .key_last   (key_last)
  );

  always_comb begin
    cur      = (state_q == ENTER_A) ? a_q : b_q;
    cur_w    = {4'b0, cur};
    next_val = (cur_w << 3) + (cur_w << 1) + {{WIDTH{1'b0}}, key_last};
    overflow = next_val > {4'b0, {WIDTH{1'b1}}};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = 1'b0;

    case (state_q)
      ENTER_A, ENTER_B: begin
        if (key_strobe) begin
          if (key_last <= KEY_DIGIT_MAX) begin
            if (overflow) begin
              ovf_d = 1'b1;
            end else if (state_q == ENTER_A) begin
              a_d = next_val[WIDTH-1:0];
            end else begin
              b_d = next_val[WIDTH-1:0];
            end
          end else if (key_last == KEY_PLUS && state_q == ENTER_A) begin
            state_d = ENTER_B;
            b_d     = '0;
          end else if (key_last == KEY_EQ && state_q == ENTER_B) begin
            state_d = SEND;
          end else if (key_last == KEY_CLR) begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
          end
        end
      end
      SEND: begin
        if (op_ready) begin
          state_d = ENTER_A;
          a_d     = '0;
          b_d     = '0;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

  assign op_a        = a_q;
  assign op_b        = b_q;
  assign op_valid    = (state_q == SEND);
  assign entry_value = (state_q == ENTER_A) ? a_q : b_q;
  assign entry_sel   = (state_q != ENTER_A);
  assign ovf_err     = ovf_q;

endmodule
